lcd_ctrl: RTL
=============

# lcd_ctrl

Character-LCD (HD44780-compatible, DE2 16x2 module) bus driver that sits directly downstream of the load/store unit's LCD control register (`o_io_lcd`). It has four jobs:
- Detect each new command the core posts to that register.
- Sequence the LCD pins with the controller's setup, enable-pulse and hold timing.
- Enforce per-command execution delays and the power-up delay.
- Buffer one pending command, so that software can post back-to-back writes without polling.

## Interface
Parameters (all in `i_clk` cycles; the defaults assume 50 MHz):
- `T_PWRUP_CYC`, default 750000: power-up wait after reset (15 ms).
- `T_SETUP_CYC`, default 4: RS/DATA stable before EN rises (80 ns).
- `T_PW_CYC`, default 16: EN high width (320 ns).
- `T_HOLD_CYC`, default 4: RS/DATA held after EN falls (80 ns).
- `T_EXEC_CYC`, default 2000: execution wait for normal commands and data (40 us).
- `T_LONG_CYC`, default 82000: execution wait for clear/home (1.64 ms).

Ports (one clock; reset is synchronous and active-high):
- `i_clk`, input, 1: system clock.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_lcd`, input, 32: LCD control word from the LSU. Fields:
  - [31] ON
  - [30] BLON
  - [10] RS
  - [8] GO toggle
  - [7:0] DATA
  - All other bits are ignored.
- `o_lcd_on`, output, 1: LCD power enable.
- `o_lcd_blon`, output, 1: backlight enable.
- `o_lcd_en`, output, 1: LCD enable strobe.
- `o_lcd_rs`, output, 1: register select (0 = command, 1 = data).
- `o_lcd_rw`, output, 1: read/write. Tied to 0 (write only).
- `o_lcd_data`, output, 8: LCD data bus.
- `o_busy`, output, 1: high while the controller is in PWRUP, is not IDLE, or holds a pending command.
- `o_overrun`, output, 1: sticky flag. Set when a pending command is overwritten.

## Operation
- **State machine.** States are PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT. A single down-counter `cnt` times every state.
- **Command detection.** A command is posted when `i_lcd[8] != go_last`, sampled at a rising edge.
  - On detection, `go_last <= i_lcd[8]`.
  - {RS, DATA} are captured from the same sample.
- **Dispatch.**
  - If the state is IDLE and the pending slot is empty, the captured command starts immediately.
  - Otherwise it goes into the one-deep pending slot.
  - If the pending slot is already full, the new command overwrites it and `o_overrun <= 1`. The latest command wins.
- **PWRUP.** Counts `T_PWRUP_CYC` cycles, then goes to IDLE.
  - EN, RS and DATA are held at 0.
  - Toggles arriving during PWRUP are captured into pending.
- **IDLE.** If pending is valid, start the pending command and clear the slot. Otherwise start on a newly detected toggle.
- **Command start.**
  - `o_lcd_rs` and `o_lcd_data` are loaded.
  - The state goes to SETUP with `cnt = T_SETUP_CYC-1`.
- **SETUP.** EN = 0. When `cnt == 0`, go to PULSE with `cnt = T_PW_CYC-1`.
- **PULSE.** EN = 1. When `cnt == 0`, go to HOLD with `cnt = T_HOLD_CYC-1`.
- **HOLD.** EN = 0, with RS and DATA unchanged. When `cnt == 0`, go to WAIT.
  - The WAIT count is `T_LONG_CYC-1` when RS = 0 and DATA[7:1] = 7'b0000000 with DATA != 0. This covers clear 0x01; and when RS = 0 and DATA[7:1] = 7'b0000001, which covers home 0x02/0x03.
  - Otherwise the WAIT count is `T_EXEC_CYC-1`.
- **WAIT.** When `cnt == 0`, go to IDLE. RS and DATA keep their last values.
- **Pass-through bits.** ON and BLON are registered pass-throughs of `i_lcd[31:30]`, updated every cycle in every state, including PWRUP.
- **Reset.**
  - All outputs go to 0, including `o_overrun`.
  - The pending slot is emptied.
  - The state goes to PWRUP with `cnt = T_PWRUP_CYC-1`.
  - `go_last <= i_lcd[8]`, so a stale toggle does not fire.
  - Reset mid-command aborts the command immediately. EN is 0 on the next cycle.

## Timing
- **Outputs.** All outputs are registered. There are no combinational paths from `i_lcd`.
- **Start latency.** A toggle first visible before edge N, with the controller IDLE and pending empty, gives SETUP from edge N. RS and DATA are valid after edge N.
- **EN pulse.** EN rises at edge N+T_SETUP_CYC and falls at edge N+T_SETUP_CYC+T_PW_CYC.
- **Command period.** Each command occupies SETUP+PW+HOLD+WAIT cycles, then 1 IDLE cycle before the pending command's SETUP.
- **Simultaneous events.** A toggle on the same edge that WAIT exits to IDLE goes to pending. It starts on the following edge.
- **`o_busy`.** Drops on the edge entering IDLE with pending empty. It rises on the edge that detects a toggle.

## Test plan
Run with overridden parameters PWRUP=10, SETUP=2, PW=3, HOLD=2, EXEC=5, LONG=20.
- **Power-up hold-off.** Release reset, then toggle GO with RS=1, DATA=0x41 at cycle 3. EN stays 0 through cycle 10. SETUP starts on the edge after PWRUP ends. EN is high for exactly 3 cycles and `o_lcd_data` = 0x41 throughout.
- **Normal timing.** In IDLE, post 0x38 (RS=0). EN rises 2 cycles after the start edge. `o_busy` stays high for 2+3+2+5 = 12 cycles and then drops.
- **Long command.** Post 0x01 (RS=0), then 0x02. Each WAIT lasts 20 cycles. Post 0x04 and its WAIT lasts 5 cycles.
- **Pending and overrun.** During PULSE of command A, post B, then C. Only A and C are issued; B never appears on `o_lcd_data`. `o_overrun` = 1 and stays set until reset.
- **Reset mid-pulse.** Assert `i_reset` while EN = 1. On the next cycle EN = 0, DATA = 0, the state is PWRUP and pending is empty. A GO level left unchanged across reset does not fire.
- **ON/BLON pass-through.** Write `i_lcd[31:30]` = 2'b11 during PWRUP and during WAIT. `o_lcd_on` and `o_lcd_blon` follow one cycle later in both cases.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// Bus between the LSU's LCD control register and the character-LCD driver.
// Signal names match the original lcd_ctrl ports so existing hookups carry over.
interface lcd_ctrl_if;
  logic [31:0] i_lcd;
  logic        o_lcd_on;
  logic        o_lcd_blon;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic        o_overrun;

  // LSU side: posts control words, observes pins and status
  modport master (
    output i_lcd,
    input  o_lcd_on,
    input  o_lcd_blon,
    input  o_lcd_en,
    input  o_lcd_rs,
    input  o_lcd_rw,
    input  o_lcd_data,
    input  o_busy,
    input  o_overrun
  );

  // Driver side: consumes control words, drives the LCD pins
  modport slave (
    input  i_lcd,
    output o_lcd_on,
    output o_lcd_blon,
    output o_lcd_en,
    output o_lcd_rs,
    output o_lcd_rw,
    output o_lcd_data,
    output o_busy,
    output o_overrun
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-compatible character-LCD bus driver.
// Detects GO toggles on the LSU control word, sequences RS/DATA/EN with
// setup, pulse and hold timing, enforces execution and power-up delays, and
// buffers one pending command (latest wins, overrun flagged).
module lcd_ctrl #(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_PW_CYC    = 16,
  parameter int unsigned T_HOLD_CYC  = 4,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000
) (
  input  logic      i_clk,
  input  logic      i_reset,
  lcd_ctrl_if.slave bus
);

  localparam logic [31:0] PWRUP_LD = 32'(T_PWRUP_CYC - 1);
  localparam logic [31:0] SETUP_LD = 32'(T_SETUP_CYC - 1);
  localparam logic [31:0] PW_LD    = 32'(T_PW_CYC - 1);
  localparam logic [31:0] HOLD_LD  = 32'(T_HOLD_CYC - 1);
  localparam logic [31:0] EXEC_LD  = 32'(T_EXEC_CYC - 1);
  localparam logic [31:0] LONG_LD  = 32'(T_LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;

  logic        go_last;
  logic        pend_valid, pend_valid_n;
  logic        pend_rs, pend_rs_n;
  logic [7:0]  pend_data, pend_data_n;

  logic        lcd_rs, lcd_rs_n;
  logic [7:0]  lcd_data, lcd_data_n;
  logic        lcd_en;
  logic        lcd_on;
  logic        lcd_blon;
  logic        busy;
  logic        overrun, overrun_n;

  logic        toggle;
  logic        new_rs;
  logic [7:0]  new_data;
  logic        long_cmd;

  logic        start;
  logic        start_rs;
  logic [7:0]  start_data;

  // Only ON, BLON, RS, GO and DATA carry meaning
  logic        unused_bits;
  assign unused_bits = ^{bus.i_lcd[29:11], bus.i_lcd[9]};

  assign toggle   = bus.i_lcd[8] != go_last;
  assign new_rs   = bus.i_lcd[10];
  assign new_data = bus.i_lcd[7:0];

  // Clear (0x01) and home (0x02/0x03) need the long execution wait
  assign long_cmd = !lcd_rs &&
                    (((lcd_data[7:1] == 7'b0000000) && (lcd_data != 8'h00)) ||
                     (lcd_data[7:1] == 7'b0000001));

  // Next-state, pending-slot and pin-value logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pend_valid_n = pend_valid;
    pend_rs_n    = pend_rs;
    pend_data_n  = pend_data;
    lcd_rs_n     = lcd_rs;
    lcd_data_n   = lcd_data;
    overrun_n    = overrun;
    start        = 1'b0;
    start_rs     = new_rs;
    start_data   = new_data;

    unique case (state)
      S_PWRUP: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 32'd1;
      end
      S_IDLE: begin
        if (pend_valid) begin
          start        = 1'b1;
          start_rs     = pend_rs;
          start_data   = pend_data;
          pend_valid_n = 1'b0;
        end else if (toggle) begin
          start = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = PW_LD;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_n = S_HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_n = S_WAIT;
          cnt_n   = long_cmd ? LONG_LD : EXEC_LD;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 32'd1;
      end
      default: begin
        state_n = S_PWRUP;
        cnt_n   = PWRUP_LD;
      end
    endcase

    if (start) begin
      state_n    = S_SETUP;
      cnt_n      = SETUP_LD;
      lcd_rs_n   = start_rs;
      lcd_data_n = start_data;
    end

    // A toggle not consumed by an immediate start lands in the slot. In IDLE
    // with a full slot, that slot is being issued this edge, so nothing is lost.
    if (toggle && !((state == S_IDLE) && !pend_valid)) begin
      if (pend_valid && (state != S_IDLE)) overrun_n = 1'b1;
      pend_valid_n = 1'b1;
      pend_rs_n    = new_rs;
      pend_data_n  = new_data;
    end
  end

  // Sequencer state, pending slot and registered LCD pins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_PWRUP;
      cnt        <= PWRUP_LD;
      go_last    <= bus.i_lcd[8];
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= '0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      lcd_en     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      go_last    <= bus.i_lcd[8];
      pend_valid <= pend_valid_n;
      pend_rs    <= pend_rs_n;
      pend_data  <= pend_data_n;
      lcd_rs     <= lcd_rs_n;
      lcd_data   <= lcd_data_n;
      lcd_en     <= (state_n == S_PULSE);
      busy       <= (state_n != S_IDLE) || pend_valid_n;
      overrun    <= overrun_n;
    end
  end

  // ON/BLON follow the control word one cycle later in every state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lcd_on   <= 1'b0;
      lcd_blon <= 1'b0;
    end else begin
      lcd_on   <= bus.i_lcd[31];
      lcd_blon <= bus.i_lcd[30];
    end
  end

  assign bus.o_lcd_on   = lcd_on;
  assign bus.o_lcd_blon = lcd_blon;
  assign bus.o_lcd_en   = lcd_en;
  assign bus.o_lcd_rs   = lcd_rs;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_data = lcd_data;
  assign bus.o_busy     = busy;
  assign bus.o_overrun  = overrun;

endmodule
